ldm_stm_sequencer: RTL and testbench

Multi-cycle block-transfer sequencer for LDM/STM, sitting between decode and the 16-entry register file. It walks a 16-bit register list from the lowest to the highest register, one register per memory beat. For STM it reads each register; for LDM it writes each returned word into its register. It also computes the four ARM addressing modes (IA/IB/DA/DB) and performs optional base writeback.

---
 rtl/ldm_stm_sequencer.sv | 133 +++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list low to high, one memory
// beat per register, computes IA/IB/DA/DB addresses and performs optional base writeback.
module ldm_stm_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         is_load,
    input  logic                         up,
    input  logic                         pre,
    input  logic                         writeback,
    input  logic [$clog2(REG_COUNT)-1:0] base_reg,
    input  logic [DATA_WIDTH-1:0]        base_addr,
    input  logic [REG_COUNT-1:0]         reglist,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic                         mem_ready,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic [$clog2(REG_COUNT)-1:0] read_reg_num1,
    input  logic [DATA_WIDTH-1:0]        read_data1,
    output logic [$clog2(REG_COUNT)-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]        write_data,
    output logic                         regwrite
);
    localparam int IDX_W = $clog2(REG_COUNT);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB} state_t;

    function automatic logic [CNT_W-1:0] f_popcount(input logic [REG_COUNT-1:0] list);
        f_popcount = '0;
        for (int i = 0; i < REG_COUNT; i++)
            f_popcount = f_popcount + CNT_W'(list[i]);
    endfunction

    function automatic logic [IDX_W-1:0] f_lowest(input logic [REG_COUNT-1:0] list);
        f_lowest = '0;
        for (int i = REG_COUNT - 1; i >= 0; i--)
            if (list[i]) f_lowest = IDX_W'(i);
    endfunction

    state_t                  r_state;
    logic [REG_COUNT-1:0]    r_list;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wb_val;
    logic                    r_is_load;
    logic                    r_wb_en;
    logic [IDX_W-1:0]        r_base_reg;

    logic [CNT_W-1:0]        w_count;
    logic [DATA_WIDTH-1:0]   w_span;
    logic [DATA_WIDTH-1:0]   w_start_addr;
    logic [DATA_WIDTH-1:0]   w_wb_val;
    logic [IDX_W-1:0]        w_cur;
    logic [REG_COUNT-1:0]    w_list_next;
    logic                    w_in_xfer;
    logic                    w_beat;
    logic                    w_ld_wr;
    logic                    w_wb_wr;

    assign w_count  = f_popcount(reglist);
    assign w_span   = DATA_WIDTH'({w_count, 2'b00});
    assign w_wb_val = up ? (base_addr + w_span) : (base_addr - w_span);

    always_comb begin
        w_start_addr = base_addr;
        case ({up, pre})
            2'b10:   w_start_addr = base_addr;
            2'b11:   w_start_addr = base_addr + DATA_WIDTH'(4);
            2'b00:   w_start_addr = base_addr - w_span + DATA_WIDTH'(4);
            default: w_start_addr = base_addr - w_span;
        endcase
    end

    // Remaining list shrinks by its lowest set bit on each completed beat.
    assign w_cur       = f_lowest(r_list);
    assign w_list_next = r_list & (r_list - REG_COUNT'(1));
    assign w_in_xfer   = (r_state == S_XFER);
    assign w_beat      = w_in_xfer & mem_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_list  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_list     <= reglist;
                        r_addr     <= w_start_addr;
                        r_wb_val   <= w_wb_val;
                        r_is_load  <= is_load;
                        r_base_reg <= base_reg;
                        // A loaded base overrides writeback; an empty list never writes back.
                        r_wb_en    <= writeback & (|reglist) & ~(is_load & reglist[base_reg]);
                        r_state    <= (reglist == '0) ? S_WB : S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_ready) begin
                        r_list <= w_list_next;
                        r_addr <= r_addr + DATA_WIDTH'(4);
                        if (w_list_next == '0) r_state <= S_WB;
                    end
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Load writes land in the beat cycle itself, so the write port decodes mem_ready directly.
    assign w_ld_wr = w_beat & r_is_load & ~reset;
    assign w_wb_wr = (r_state == S_WB) & r_wb_en & ~reset;

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_WB);
    assign mem_req       = w_in_xfer;
    assign mem_we        = w_in_xfer & ~r_is_load;
    assign mem_addr      = w_in_xfer ? r_addr : '0;
    assign read_reg_num1 = mem_we ? w_cur : '0;
    assign mem_wdata     = mem_we ? read_data1 : '0;
    assign regwrite      = w_ld_wr | w_wb_wr;
    assign write_reg     = w_ld_wr ? w_cur : (w_wb_wr ? r_base_reg : '0);
    assign write_data    = w_ld_wr ? mem_rdata : (w_wb_wr ? r_wb_val : '0);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a register-file model and a
// configurable-latency memory responder.
module tb_ldm_stm_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        up = 1'b0;
    logic        pre = 1'b0;
    logic        writeback = 1'b0;
    logic [3:0]  base_reg = 4'd0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] reglist = 16'd0;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  read_reg_num1;
    logic [31:0] read_data1;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic        regwrite;

    ldm_stm_sequencer #(.DATA_WIDTH(32), .REG_COUNT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .is_load(is_load), .up(up), .pre(pre),
        .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr), .reglist(reglist),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .read_reg_num1(read_reg_num1), .read_data1(read_data1), .write_reg(write_reg),
        .write_data(write_data), .regwrite(regwrite)
    );

    always #5 clock = ~clock;

    // Register file model
    logic [31:0] rf [16];
    assign read_data1 = rf[read_reg_num1];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'hA000_0000 + 32'(i);
        end else if (regwrite) begin
            rf[write_reg] <= write_data;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder
    int          rdy_delay = 0;
    int          wcnt = 0;
    logic        idle_ready = 1'b0;
    logic        rdata_force_en = 1'b0;
    logic [31:0] rdata_force = 32'd0;
    always @(negedge clock) begin
        if (mem_req) begin
            if (wcnt >= rdy_delay) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
            mem_rdata = rdata_force_en ? rdata_force : mem_val(mem_addr);
        end else begin
            mem_ready = idle_ready;
            mem_rdata = 32'hBAD0_BAD0;
            wcnt = 0;
        end
    end

    // Event logs
    logic [31:0] bq_addr[$];
    logic [31:0] bq_data[$];
    logic        bq_we[$];
    int          bq_cyc[$];
    logic [3:0]  wq_reg[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          dq_cyc[$];
    int          req_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;

    always @(negedge clock) begin
        #2;
        if (mem_req) req_cnt++;
        if (prev_wait) begin
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_wdata", mem_wdata, prev_wdata);
            chk("hold_we", 32'(mem_we), 32'(prev_we));
        end
        prev_wait  = mem_req && !mem_ready;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_we    = mem_we;
        if (mem_req && mem_ready) begin
            bq_addr.push_back(mem_addr);
            bq_data.push_back(mem_wdata);
            bq_we.push_back(mem_we);
            bq_cyc.push_back(cyc);
        end
        if (regwrite) begin
            wq_reg.push_back(write_reg);
            wq_data.push_back(write_data);
            wq_cyc.push_back(cyc);
        end
        if (done) dq_cyc.push_back(cyc);
    end

    int t_start = 0;

    task automatic tick;
        @(negedge clock);
        #3;
    endtask

    task automatic clear_logs;
        bq_addr.delete(); bq_data.delete(); bq_we.delete(); bq_cyc.delete();
        wq_reg.delete(); wq_data.delete(); wq_cyc.delete(); dq_cyc.delete();
        req_cnt = 0;
        prev_wait = 1'b0;
    endtask

    task automatic start_xfer(input logic ld, input logic u, input logic p, input logic wb,
                              input logic [3:0] br, input logic [31:0] ba, input logic [15:0] rl);
        tick;
        clear_logs;
        is_load = ld; up = u; pre = p; writeback = wb;
        base_reg = br; base_addr = ba; reglist = rl;
        start = 1'b1;
        t_start = cyc;
        tick;
        start = 1'b0;
    endtask

    // Waits for done; with hold_start, start stays high and inputs are scrambled while busy.
    task automatic wait_done(input string tag, input int limit, input logic hold_start);
        int n;
        n = 0;
        while (dq_cyc.size() == 0 && n < limit) begin
            if (hold_start) begin
                start = 1'b1; reglist = 16'hFFFF; base_addr = 32'd0; is_load = 1'b1;
            end
            tick;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(dq_cyc.size()), 32'd1);
        tick;
        start = 1'b0;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_once"}, 32'(dq_cyc.size()), 32'd1);
    endtask

    task automatic chk_beat(input string tag, input int k, input logic [31:0] a, input logic we,
                            input logic chk_d, input logic [31:0] d, input int c);
        if (k < bq_addr.size()) begin
            chk({tag, "_addr"}, bq_addr[k], a);
            chk({tag, "_we"}, 32'(bq_we[k]), 32'(we));
            if (chk_d) chk({tag, "_wdata"}, bq_data[k], d);
            chk({tag, "_cyc"}, bq_cyc[k], c);
        end
    endtask

    task automatic chk_wr(input string tag, input int k, input logic [3:0] r,
                          input logic [31:0] d, input int c);
        if (k < wq_reg.size()) begin
            chk({tag, "_reg"}, 32'(wq_reg[k]), 32'(r));
            chk({tag, "_data"}, wq_data[k], d);
            chk({tag, "_cyc"}, wq_cyc[k], c);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_regwrite"}, 32'(regwrite), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_write_reg"}, 32'(write_reg), 32'd0);
        chk({tag, "_write_data"}, write_data, 32'd0);
        chk({tag, "_rd_num"}, 32'(read_reg_num1), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick; tick; tick;
        chk_idle_outputs("rst");
        reset = 1'b0;
        tick;
        chk_idle_outputs("idle");

        // STM IA, R0..R3 to 0x1000, base R13 written back
        start_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h1000, 16'h000F);
        wait_done("t1", 50, 1'b0);
        chk("t1_nbeats", 32'(bq_addr.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk_beat("t1_beat", k, 32'h1000 + 32'(4 * k), 1'b1, 1'b1, 32'hA000_0000 + 32'(k), t_start + 1 + k);
        chk("t1_nwr", 32'(wq_reg.size()), 32'd1);
        chk_wr("t1_wb", 0, 4'd13, 32'h1010, t_start + 5);
        chk("t1_done_cyc", dq_cyc.size() > 0 ? dq_cyc[0] : -1, t_start + 5);

        // LDM DB, no writeback
        start_xfer(1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 32'h2000, 16'h8002);
        wait_done("t2", 50, 1'b0);
        chk("t2_nbeats", 32'(bq_addr.size()), 32'd2);
        chk_beat("t2_beat0", 0, 32'h1FF8, 1'b0, 1'b0, 32'd0, t_start + 1);
        chk_beat("t2_beat1", 1, 32'h1FFC, 1'b0, 1'b0, 32'd0, t_start + 2);
        chk("t2_nwr", 32'(wq_reg.size()), 32'd2);
        chk_wr("t2_ld0", 0, 4'd1, 32'h5A5A_1FF8, t_start + 1);
        chk_wr("t2_ld1", 1, 4'd15, 32'h5A5A_1FFC, t_start + 2);
        chk("t2_done_cyc", dq_cyc.size() > 0 ? dq_cyc[0] : -1, t_start + 3);

        // LDM IA loading its own base: loaded value wins
        rdata_force_en = 1'b1;
        rdata_force = 32'hDEAD_BEEF;
        start_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0100, 16'h0004);
        wait_done("t3", 50, 1'b0);
        rdata_force_en = 1'b0;
        chk("t3_nbeats", 32'(bq_addr.size()), 32'd1);
        chk_beat("t3_beat0", 0, 32'h0100, 1'b0, 1'b0, 32'd0, t_start + 1);
        chk("t3_nwr", 32'(wq_reg.size()), 32'd1);
        chk_wr("t3_ld", 0, 4'd2, 32'hDEAD_BEEF, t_start + 1);
        chk("t3_rf_r2", rf[2], 32'hDEAD_BEEF);

        // STM IB with 3 wait states per beat, start held high while busy
        rdy_delay = 3;
        start_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 32'h3000, 16'h0030);
        wait_done("t4", 60, 1'b1);
        rdy_delay = 0;
        chk("t4_nbeats", 32'(bq_addr.size()), 32'd2);
        chk_beat("t4_beat0", 0, 32'h3004, 1'b1, 1'b1, 32'hA000_0004, t_start + 4);
        chk_beat("t4_beat1", 1, 32'h3008, 1'b1, 1'b1, 32'hA000_0005, t_start + 8);
        chk("t4_req_cycles", 32'(req_cnt), 32'd8);
        chk("t4_nwr", 32'(wq_reg.size()), 32'd1);
        chk_wr("t4_wb", 0, 4'd13, 32'h3008, t_start + 9);

        // Empty list, mem_ready asserted while idle
        idle_ready = 1'b1;
        start_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h7000, 16'h0000);
        wait_done("t5", 20, 1'b0);
        idle_ready = 1'b0;
        chk("t5_done_cyc", dq_cyc.size() > 0 ? dq_cyc[0] : -1, t_start + 1);
        chk("t5_req_cycles", 32'(req_cnt), 32'd0);
        chk("t5_nbeats", 32'(bq_addr.size()), 32'd0);
        chk("t5_nwr", 32'(wq_reg.size()), 32'd0);

        // Reset during the 2nd beat of a 4-register LDM
        start_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h4000, 16'h0F00);
        @(negedge clock);
        reset = 1'b1;
        #3;
        tick;
        reset = 1'b0;
        chk_idle_outputs("t6_after_rst");
        tick; tick; tick;
        chk("t6_nwr", 32'(wq_reg.size()), 32'd1);
        chk_wr("t6_ld0", 0, 4'd8, 32'h5A5A_4000, t_start + 1);
        chk("t6_no_done", 32'(dq_cyc.size()), 32'd0);

        // Fresh transfer after the abandoned one
        start_xfer(1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 32'h5000, 16'h0300);
        wait_done("t7", 50, 1'b0);
        chk("t7_nwr", 32'(wq_reg.size()), 32'd2);
        chk_wr("t7_ld0", 0, 4'd8, 32'h5A5A_5000, t_start + 1);
        chk_wr("t7_ld1", 1, 4'd9, 32'h5A5A_5004, t_start + 2);
        chk("t7_done_cyc", dq_cyc.size() > 0 ? dq_cyc[0] : -1, t_start + 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
